serial_mag_comparator: RTL and testbench

Bit-serial magnitude comparator for two WIDTH-bit operands. Operands are presented in parallel with a start pulse. The block shifts them MSB-first through a single-bit compare cell, feeding the less/greater/equal cascade state back each cycle. It reports a one-hot lt/gt/eq result with a done pulse, trading the area of a parallel comparator chain for WIDTH cycles of latency.

---
 rtl/serial_cmp_pkg.sv | 29 ++
 rtl/serial_cmp_cell.sv | 30 +++
 rtl/serial_mag_comparator.sv | 106 ++++++++++
 tb/tb_serial_mag_comparator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic cl;
    logic cg;
    logic ce;
  } cascade_t;

  // Cascade value at the start of every comparison: "equal so far".
  localparam cascade_t CASCADE_EQ = '{cl: 1'b0, cg: 1'b0, ce: 1'b1};

  // Bits needed to hold values 0..n-1; never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// One-bit compare cell: folds a bit pair into the lt/gt/eq cascade; combinational.
// Latency: none. Backpressure: none.
module serial_cmp_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic cl,
  input  logic cg,
  input  logic ce,
  output logic next_cl,
  output logic next_cg,
  output logic next_ce
);

  // Once a difference has been seen, lower bits no longer matter.
  always_comb begin
    next_cl = cl;
    next_cg = cg;
    next_ce = ce;
    if (!cl && !cg && ce) begin
      if (a_bit && !b_bit) begin
        next_cg = 1'b1;
        next_ce = 1'b0;
      end else if (!a_bit && b_bit) begin
        next_cl = 1'b1;
        next_ce = 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator; one-hot lt/gt/eq with a done pulse.
// Latency: WIDTH+1 edges from accepted start to done; start ignored while busy.
// SERIAL_CMP_SIGNED_EN selects two's-complement operands (MSBs inverted at load).
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int CW = clog2(WIDTH);

`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [WIDTH-1:0] MSB_FLIP = '0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic [CW-1:0]    cnt_q;
  cascade_t         cas_q, cas_nxt;
  logic             load;
  logic             last_bit;

  assign load     = start && (state_q == IDLE || state_q == DONE);
  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);

  serial_cmp_cell u_cell (
    .a_bit   (sa_q[WIDTH-1]),
    .b_bit   (sb_q[WIDTH-1]),
    .cl      (cas_q.cl),
    .cg      (cas_q.cg),
    .ce      (cas_q.ce),
    .next_cl (cas_nxt.cl),
    .next_cg (cas_nxt.cg),
    .next_ce (cas_nxt.ce)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= '0;
      sb_q  <= '0;
      cnt_q <= '0;
      cas_q <= CASCADE_EQ;
    end else if (load) begin
      sa_q  <= a ^ MSB_FLIP;
      sb_q  <= b ^ MSB_FLIP;
      cnt_q <= CW'(WIDTH - 1);
      cas_q <= CASCADE_EQ;
    end else if (state_q == SHIFT) begin
      sa_q  <= {sa_q[WIDTH-2:0], 1'b0};
      sb_q  <= {sb_q[WIDTH-2:0], 1'b0};
      cas_q <= cas_nxt;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Results only move on the final bit, so they show the previous answer while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt <= 1'b0;
      gt <= 1'b0;
      eq <= 1'b0;
    end else if (last_bit) begin
      lt <= cas_nxt.cl;
      gt <= cas_nxt.cg;
      eq <= cas_nxt.ce;
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomized bench for serial_mag_comparator against a plain-arithmetic reference.
module tb_serial_mag_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         lt;
  logic         gt;
  logic         eq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] prev_res;

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .gt    (gt),
    .eq    (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {lt,gt,eq} straight from the numeric comparison.
  function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_SIGNED_EN
    if ($signed(x) < $signed(y)) return 3'b100;
    if ($signed(x) > $signed(y)) return 3'b010;
`else
    if (x < y) return 3'b100;
    if (x > y) return 3'b010;
`endif
    return 3'b001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_after_start", {31'd0, done}, 32'd0);
  endtask

  // Waits for done after issue(); optionally pokes start at edge disturb_at.
  // With restart set, returns in the DONE cycle so the caller can issue again.
  task automatic finish_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                            input int disturb_at, input bit restart);
    logic [2:0] exp_res;
    bit seen;
    exp_res = model(x, y);
    seen = 1'b0;
    for (int k = 1; k <= W + 4 && !seen; k++) begin
      if (k == disturb_at) begin
        start = 1'b1;
        a = ~x;
        b = x;
      end
      tick();
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk("latency", k, W);
        chk("result", {29'd0, lt, gt, eq}, {29'd0, exp_res});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        prev_res = exp_res;
      end else begin
        chk("held_while_busy", {29'd0, lt, gt, eq}, {29'd0, prev_res});
        chk("busy_during", {31'd0, busy}, 32'd1);
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    if (!restart) begin
      tick();
      chk("done_falls", {31'd0, done}, 32'd0);
      chk("idle_not_busy", {31'd0, busy}, 32'd0);
      chk("result_held", {29'd0, lt, gt, eq}, {29'd0, prev_res});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    prev_res = 3'b000;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {29'd0, lt, gt, eq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {30'd0, busy, done}, 32'd0);

    issue(8'h5A, 8'h5A);
    finish_cmp(8'h5A, 8'h5A, 0, 1'b0);
    issue(8'h01, 8'h02);
    finish_cmp(8'h01, 8'h02, 0, 1'b0);
    issue(8'hF0, 8'h0F);
    finish_cmp(8'hF0, 8'h0F, 0, 1'b0);
    issue(8'h80, 8'h7F);
    finish_cmp(8'h80, 8'h7F, 0, 1'b0);

    // Start while busy must be ignored; finish_cmp also proves a single done.
    issue(8'h33, 8'h34);
    finish_cmp(8'h33, 8'h34, 3, 1'b0);
    tick();
    chk("no_second_done", {31'd0, done}, 32'd0);
    chk("no_restart", {31'd0, busy}, 32'd0);

    // Back-to-back: eq result must survive until the second completion.
    issue(8'h5A, 8'h5A);
    finish_cmp(8'h5A, 8'h5A, 0, 1'b1);
    issue(8'h10, 8'h20);
    finish_cmp(8'h10, 8'h20, 0, 1'b0);

    // Reset mid-comparison aborts with no later done.
    issue(8'hC3, 8'h3C);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_res", {29'd0, lt, gt, eq}, 32'd0);
    prev_res = 3'b000;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit any_done;
      any_done = 1'b0;
      for (int k = 0; k < W + 3; k++) begin
        tick();
        if (done || busy) any_done = 1'b1;
      end
      chk("no_done_after_abort", {31'd0, any_done}, 32'd0);
      chk("abort_res_held", {29'd0, lt, gt, eq}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
        default: y = W'($urandom);
      endcase
      issue(x, y);
      finish_cmp(x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0,
                 ($urandom_range(0, 1) == 1) && (i != 39));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
